// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch front end driving a req/ack instruction bus and the IF/ID interface.
// Owns the PC and handles stall hold, branch redirect and flush redirect with in-flight drop.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_ack_i,
   input  logic [31:0] ibus_rdata_i,
   output logic [31:0] if_pc_o,
   output logic [31:0] rom_inst_o,
   output logic        stallreq_o
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;
   state_t state, state_nxt;
   logic [31:0] pc, pc_nxt, hold_inst, hold_nxt, redir, redir_nxt;
   logic [31:0] next_pc, flush_pc;
   logic        present;
   assign next_pc  = branch_flag_i ? {branch_target_i[31:2], 2'b00} : pc + 32'd4;
   assign flush_pc = {new_pc_i[31:2], 2'b00};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         hold_inst <= '0;
         redir     <= '0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         hold_inst <= hold_nxt;
         redir     <= redir_nxt;
      end
   end
   // pc only moves on an accepted instruction, a stall release, or a redirect
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      hold_nxt  = hold_inst;
      redir_nxt = redir;
      case (state)
         IDLE: begin
            state_nxt = REQ;
            if (flush_i) pc_nxt = flush_pc;
         end
         REQ: begin
            if (flush_i) begin
               if (ibus_ack_i) pc_nxt = flush_pc;
               else begin
                  redir_nxt = flush_pc;
                  state_nxt = DROP;
               end
            end else if (ibus_ack_i) begin
               if (stall[0]) begin
                  hold_nxt  = ibus_rdata_i;
                  state_nxt = HOLD;
               end else pc_nxt = next_pc;
            end
         end
         HOLD: begin
            if (flush_i || !stall[0]) begin
               pc_nxt    = flush_i ? flush_pc : next_pc;
               hold_nxt  = '0;
               state_nxt = REQ;
            end
         end
         DROP: begin
            if (flush_i) redir_nxt = flush_pc;
            if (ibus_ack_i) begin
               pc_nxt    = flush_i ? flush_pc : redir;
               state_nxt = REQ;
            end
         end
      endcase
   end
   always_comb begin
      ibus_req_o  = (state == REQ) || (state == DROP);
      ibus_addr_o = ibus_req_o ? pc : '0;
      present     = (state == REQ) && ibus_ack_i && !stall[0] && !flush_i;
      if_pc_o     = (present || state == HOLD) ? pc : '0;
      rom_inst_o  = present ? ibus_rdata_i : (state == HOLD) ? hold_inst : '0;
      stallreq_o  = (state == REQ) && !ibus_ack_i;
   end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed-vector bench for if_fetch_unit with hand-computed expectations.
module tb_if_fetch_unit;
   logic        clk = 0;
   logic        rst;
   logic [5:0]  stall;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   logic        flush_i;
   logic [31:0] new_pc_i;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_ack_i;
   logic [31:0] ibus_rdata_i;
   logic [31:0] if_pc_o;
   logic [31:0] rom_inst_o;
   logic        stallreq_o;
   int n_tests = 0;
   int n_fail = 0;

   if_fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall),
      .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
      .flush_i(flush_i), .new_pc_i(new_pc_i),
      .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
      .ibus_ack_i(ibus_ack_i), .ibus_rdata_i(ibus_rdata_i),
      .if_pc_o(if_pc_o), .rom_inst_o(rom_inst_o), .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // advance one edge, then apply this cycle's inputs and let outputs settle
   task automatic drive(input logic ack, input logic [31:0] rdata, input logic stl,
                        input logic br, input logic [31:0] tgt, input logic fl, input logic [31:0] npc);
      @(posedge clk);
      #1;
      ibus_ack_i = ack; ibus_rdata_i = rdata; stall = {5'd0, stl};
      branch_flag_i = br; branch_target_i = tgt; flush_i = fl; new_pc_i = npc;
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"}, {31'd0, ibus_req_o}, 0);
      chk({tag, "_addr"}, ibus_addr_o, 0);
      chk({tag, "_pc"}, if_pc_o, 0);
      chk({tag, "_inst"}, rom_inst_o, 0);
      chk({tag, "_stallreq"}, {31'd0, stallreq_o}, 0);
   endtask

   initial begin
      rst = 0; stall = 0; branch_flag_i = 0; branch_target_i = 0; flush_i = 0;
      new_pc_i = 0; ibus_ack_i = 0; ibus_rdata_i = 0;
      #1 rst = 1;
      #1 chk_all_zero("reset");
      @(posedge clk);
      #1 rst = 0;
      #1 chk_all_zero("idle");
      // zero-wait fetches of 0 and 4
      for (int k = 0; k < 2; k++) begin
         drive(1, 32'hA000_0000 | (4 * k), 0, 0, 0, 0, 0);
         chk("zw_req", {31'd0, ibus_req_o}, 1);
         chk("zw_addr", ibus_addr_o, 4 * k);
         chk("zw_pc", if_pc_o, 4 * k);
         chk("zw_inst", rom_inst_o, 32'hA000_0000 | (4 * k));
         chk("zw_stallreq", {31'd0, stallreq_o}, 0);
      end
      // ack delayed 3 cycles on 0x8
      for (int k = 0; k < 3; k++) begin
         drive(0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
         chk("wait_stallreq", {31'd0, stallreq_o}, 1);
         chk("wait_addr", ibus_addr_o, 32'h8);
         chk("wait_inst", rom_inst_o, 0);
      end
      drive(1, 32'h3C01_1234, 0, 0, 0, 0, 0);
      chk("ack8_inst", rom_inst_o, 32'h3C01_1234);
      chk("ack8_pc", if_pc_o, 32'h8);
      chk("ack8_stallreq", {31'd0, stallreq_o}, 0);
      drive(1, 32'hA000_000C, 0, 0, 0, 0, 0);
      chk("addr_c", ibus_addr_o, 32'hC);
      chk("inst_c", rom_inst_o, 32'hA000_000C);
      // ack for 0x10 under stall, held two cycles
      drive(1, 32'h1234_5678, 1, 0, 0, 0, 0);
      chk("stall_ack_addr", ibus_addr_o, 32'h10);
      for (int k = 0; k < 2; k++) begin
         drive(0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
         chk("hold_req", {31'd0, ibus_req_o}, 0);
         chk("hold_pc", if_pc_o, 32'h10);
         chk("hold_inst", rom_inst_o, 32'h1234_5678);
         chk("hold_stallreq", {31'd0, stallreq_o}, 0);
      end
      drive(0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
      chk("release_inst", rom_inst_o, 32'h1234_5678);
      drive(1, 32'hA000_0014, 0, 0, 0, 0, 0);
      chk("after_hold_addr", ibus_addr_o, 32'h14);
      chk("after_hold_req", {31'd0, ibus_req_o}, 1);
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("addr_18", ibus_addr_o, 32'h18);
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("addr_1c", ibus_addr_o, 32'h1C);
      // branch at the 0x20 advance cycle, low bits of target cleared
      drive(1, 32'hB000_0020, 0, 1, 32'h0000_0203, 0, 0);
      chk("br_pc", if_pc_o, 32'h20);
      drive(1, 32'hB000_0200, 0, 1, 32'h0000_0031, 0, 0);
      chk("br_addr", ibus_addr_o, 32'h200);
      // flush during un-acked request to 0x30
      drive(0, 0, 0, 0, 0, 1, 32'h180);
      chk("fl_addr", ibus_addr_o, 32'h30);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("drop_req", {31'd0, ibus_req_o}, 1);
      chk("drop_addr", ibus_addr_o, 32'h30);
      chk("drop_stallreq", {31'd0, stallreq_o}, 0);
      drive(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
      chk("drop_inst", rom_inst_o, 0);
      chk("drop_pc", if_pc_o, 0);
      // flush coinciding with an ack: data dropped, redirect immediate
      drive(1, 32'hCAFE_F00D, 0, 0, 0, 1, 32'h1C7);
      chk("fl_ack_addr", ibus_addr_o, 32'h180);
      chk("fl_ack_inst", rom_inst_o, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("fl_ack_next", ibus_addr_o, 32'h1C4);
      // asynchronous reset mid-request
      #1 rst = 1;
      #1 chk_all_zero("async_rst");
      @(posedge clk);
      #1 rst = 0;
      #1 chk_all_zero("rst_idle");
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("rst_req", {31'd0, ibus_req_o}, 1);
      chk("rst_addr", ibus_addr_o, 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end and the producer side of the IF/ID interface.
- Owns the PC and issues one word fetch at a time on a req/ack instruction bus.
- Presents `if_pc_o`/`rom_inst_o` to `if_id` under control of the 6-bit stall vector (`stall[0]` = PC stage).
- Raises `stallreq_o` while a fetch is outstanding; handles branch redirect from ID and flush redirect from the exception logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  reset_status_t  reset; asynchronous, active-high (RST_ENABLE)
- stall  input  6  pipeline stall vector; only `stall[0]` is used here
- branch_flag_i  input  1  branch taken, resolved in ID
- branch_target_i  input  32  branch target address
- flush_i  input  1  pipeline flush request
- new_pc_i  input  32  redirect address accompanying `flush_i`
- ibus_req_o  output  1  fetch request
- ibus_addr_o  output  32  fetch address, word aligned
- ibus_ack_i  input  1  fetch complete; `ibus_rdata_i` is valid in the same cycle
- ibus_rdata_i  input  32  fetched instruction word
- if_pc_o  output  inst_addr_t  PC of the presented instruction; 0 when no instruction is presented
- rom_inst_o  output  inst_t  presented instruction word; 0 when no instruction is presented
- stallreq_o  output  1  IF stall request to the pipeline controller

Behaviour:
- **Reset (asynchronous):**
  - pc = RESET_PC, state = IDLE, buffers cleared.
  - All outputs 0 while `rst` is asserted.
  - Reset mid-fetch abandons the transaction; the bus side must tolerate a dropped request.
- **States:** IDLE, REQ, HOLD, DROP.
- **IDLE** (first cycle after reset release):
  - `ibus_req_o` = 0, `stallreq_o` = 0, outputs 0.
  - Next state: REQ.
- **REQ:**
  - `ibus_req_o` = 1, `ibus_addr_o` = pc.
  - Bus rule: once `ibus_req_o` is raised, the address is held stable and `ibus_req_o` stays high until an `ibus_ack_i` cycle.
  - ack = 0: `stallreq_o` = 1, outputs 0, stay in REQ.
  - ack = 1 and `stall[0]` = 0:
    - Combinationally drive `if_pc_o` = pc and `rom_inst_o` = `ibus_rdata_i`, with `stallreq_o` = 0.
    - At the clock edge, pc := next_pc and stay in REQ, so back-to-back fetches give 1 instruction per cycle with a zero-wait bus.
  - ack = 1 and `stall[0]` = 1: latch pc and rdata into the hold buffer, go to HOLD.
- **HOLD:**
  - `ibus_req_o` = 0, `stallreq_o` = 0.
  - Outputs present the buffered pc/instruction continuously.
  - When `stall[0]` = 0: pc := next_pc, go to REQ.
- **next_pc:** `branch_flag_i` ? `{branch_target_i[31:2], 2'b00}` : pc + 4, using modulo-2^32 wrap.
  - `branch_flag_i` is sampled only in the cycle pc advances; ID holds it stable while stalled.
- **Flush** (highest priority; sampled every cycle in any state):
  - IDLE or HOLD: pc := `{new_pc_i[31:2], 2'b00}`, buffer discarded, go to REQ.
  - REQ with ack this cycle: returned data is dropped (outputs 0 that cycle), pc := new address, stay in REQ.
  - REQ without ack: latch new address into the redirect register, go to DROP.
- **DROP:**
  - Keep `ibus_req_o` = 1 on the old address; `stallreq_o` = 0; outputs 0.
  - On ack: discard data, pc := redirect address, go to REQ.
  - A further `flush_i` in DROP overwrites the redirect register (last flush wins).
- **Priority:** `flush_i` over `branch_flag_i` over sequential increment.
- **Stall only:** stall without flush never changes pc, and never drops or re-issues a captured instruction.

Test Plan:
1. Zero-wait bus (ack every request cycle), no stall, RESET_PC = 0 → `ibus_addr_o` sequence 0, 4, 8, C on consecutive cycles after IDLE; `if_pc_o` matches and `stallreq_o` stays 0.
2. Ack delayed 3 cycles on address 0x8 → `stallreq_o` = 1 for 3 cycles, `ibus_addr_o` held at 0x8; on the ack cycle `rom_inst_o` equals rdata (e.g. 0x3C01_1234) and the next address is 0xC.
3. Ack for 0x10 arrives with `stall[0]` = 1 for 2 cycles → `if_pc_o` = 0x10 with the latched instruction held stable, `ibus_req_o` = 0; after stall release the next request is 0x14.
4. `branch_flag_i` = 1, `branch_target_i` = 0x0000_0203 at the advance cycle after pc 0x20 → next `ibus_addr_o` = 0x200.
5. `flush_i` with `new_pc_i` = 0x180 during an un-acked request to 0x30 → request stays on 0x30 until ack, its data never appears on outputs, next request is 0x180.
6. Assert `rst` asynchronously mid-REQ → all outputs 0 immediately; after release, IDLE for one cycle, then a request to RESET_PC.
